// File: rtl/dma_pkg.sv
// Shared types for the DMA transfer engine: one-hot sequencer states,
// transfer direction codes and the per-channel mode word.
package dma_pkg;

  typedef logic [5:0] state_t;

  localparam state_t ST_SI = 6'b000001;
  localparam state_t ST_S0 = 6'b000010;
  localparam state_t ST_S1 = 6'b000100;
  localparam state_t ST_S2 = 6'b001000;
  localparam state_t ST_S3 = 6'b010000;
  localparam state_t ST_S4 = 6'b100000;

  localparam logic [1:0] DIR_VERIFY = 2'b00;
  localparam logic [1:0] DIR_WRITE  = 2'b01;
  localparam logic [1:0] DIR_READ   = 2'b10;

  // Field order matches the cfg_mode bit layout so a plain cast unpacks it.
  typedef struct packed {
    logic       block;
    logic       decr;
    logic       autoinit;
    logic [1:0] dir;
  } mode_t;

endpackage

// File: rtl/dma_prio_arbiter.sv
// Combinational DREQ arbiter: lowest index wins, or in rotating mode the
// search starts at rot_ptr and wraps. Zero latency, no state.
module dma_prio_arbiter #(
  parameter int NUM_CH = 4,
  localparam int IDX_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rot_ptr,
  input  logic              cmd_rot,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = cmd_rot ? IDX_W'((int'(rot_ptr) + k) % NUM_CH) : IDX_W'(k);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/dma_xfer_engine.sv
// N-channel DMA timing/control sequencer (SI, S0, S1..S4): bus-hold handshake,
// arbitration, strobe sequencing; READY low stretches S3, HLDA gates entry to S1.
module dma_xfer_engine
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [ADDR_W-1:0]         cfg_addr,
  input  logic [CNT_W-1:0]          cfg_cnt,
  input  logic [4:0]                cfg_mode,
  input  logic                      cmd_en,
  input  logic                      cmd_rot,
  input  logic [NUM_CH-1:0]         mask,
  input  logic [NUM_CH-1:0]         DREQ,
  input  logic                      HLDA,
  input  logic                      READY,
  output logic                      HRQ,
  output logic [NUM_CH-1:0]         DACK,
  output logic                      AEN,
  output logic                      ADSTB,
  output logic [ADDR_W-1:0]         ADDR,
  output logic                      MEMR_N,
  output logic                      MEMW_N,
  output logic                      IOR_N,
  output logic                      IOW_N,
  output logic                      EOP_N,
  output logic [NUM_CH-1:0]         tc_status
);

  localparam int IDX_W = $clog2(NUM_CH);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   act_ch;
  logic [IDX_W-1:0]   rot_ptr;
  logic [ADDR_W-1:0]  base_addr [NUM_CH];
  logic [ADDR_W-1:0]  cur_addr  [NUM_CH];
  logic [CNT_W-1:0]   base_cnt  [NUM_CH];
  logic [CNT_W-1:0]   cur_cnt   [NUM_CH];
  mode_t              mode_q    [NUM_CH];
  logic [NUM_CH-1:0]  dis_q;
  logic [NUM_CH-1:0]  tc_q;

  logic               pend_vld;
  logic [ADDR_W-1:0]  pend_addr;
  logic [CNT_W-1:0]   pend_cnt;
  mode_t              pend_mode;

  logic [NUM_CH-1:0]  req;
  logic [NUM_CH-1:0]  gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               in_si, in_s0, in_s1, in_s2, in_s3, in_s4, active;
  logic               is_tc;
  mode_t              act_mode;
  logic [IDX_W-1:0]   rot_next;

  // Channels that reached TC without autoinit stay out of arbitration until reprogrammed.
  assign req = DREQ & ~mask & {NUM_CH{cmd_en}} & ~dis_q;

  dma_prio_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (req),
    .rot_ptr   (rot_ptr),
    .cmd_rot   (cmd_rot),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign gnt_any  = |gnt;
  assign in_si    = (state_q == ST_SI);
  assign in_s0    = (state_q == ST_S0);
  assign in_s1    = (state_q == ST_S1);
  assign in_s2    = (state_q == ST_S2);
  assign in_s3    = (state_q == ST_S3);
  assign in_s4    = (state_q == ST_S4);
  assign active   = in_s1 | in_s2 | in_s3 | in_s4;
  assign act_mode = mode_q[act_ch];
  assign is_tc    = (cur_cnt[act_ch] == '0);
  assign rot_next = (act_ch == IDX_W'(NUM_CH - 1)) ? '0 : act_ch + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SI: if (gnt_any) state_d = ST_S0;
      ST_S0: begin
        if (!gnt_any)  state_d = ST_SI;
        else if (HLDA) state_d = ST_S1;
      end
      ST_S1: state_d = ST_S2;
      ST_S2: state_d = ST_S3;
      ST_S3: if (READY) state_d = ST_S4;
      ST_S4: begin
        // Block mode keeps the bus only while the hold is still granted.
        if (!is_tc && act_mode.block && HLDA) state_d = ST_S1;
        else                                  state_d = ST_SI;
      end
      default: state_d = ST_SI;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_SI;
      act_ch    <= '0;
      rot_ptr   <= '0;
      dis_q     <= '0;
      tc_q      <= '0;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
      pend_cnt  <= '0;
      pend_mode <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        base_addr[i] <= '0;
        cur_addr[i]  <= '0;
        base_cnt[i]  <= '0;
        cur_cnt[i]   <= '0;
        mode_q[i]    <= '0;
      end
    end else begin
      state_q <= state_d;

      if (in_s0 && gnt_any && HLDA) act_ch <= gnt_idx;

      if (in_s4) begin
        cur_addr[act_ch] <= act_mode.decr ? cur_addr[act_ch] - ADDR_W'(1)
                                          : cur_addr[act_ch] + ADDR_W'(1);
        cur_cnt[act_ch]  <= cur_cnt[act_ch] - CNT_W'(1);
        if (cmd_rot) rot_ptr <= rot_next;
        if (is_tc) begin
          tc_q[act_ch] <= 1'b1;
          if (act_mode.autoinit) begin
            cur_addr[act_ch] <= base_addr[act_ch];
            cur_cnt[act_ch]  <= base_cnt[act_ch];
          end else begin
            dis_q[act_ch] <= 1'b1;
          end
        end
      end

      // A write deferred against the active channel lands once the bus is released.
      if (pend_vld && in_si) begin
        base_addr[act_ch] <= pend_addr;
        cur_addr[act_ch]  <= pend_addr;
        base_cnt[act_ch]  <= pend_cnt;
        cur_cnt[act_ch]   <= pend_cnt;
        mode_q[act_ch]    <= pend_mode;
        tc_q[act_ch]      <= 1'b0;
        dis_q[act_ch]     <= 1'b0;
        pend_vld          <= 1'b0;
      end

      if (cfg_we) begin
        if (active && cfg_ch == act_ch) begin
          pend_vld  <= 1'b1;
          pend_addr <= cfg_addr;
          pend_cnt  <= cfg_cnt;
          pend_mode <= mode_t'(cfg_mode);
        end else begin
          base_addr[cfg_ch] <= cfg_addr;
          cur_addr[cfg_ch]  <= cfg_addr;
          base_cnt[cfg_ch]  <= cfg_cnt;
          cur_cnt[cfg_ch]   <= cfg_cnt;
          mode_q[cfg_ch]    <= mode_t'(cfg_mode);
          tc_q[cfg_ch]      <= 1'b0;
          dis_q[cfg_ch]     <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    DACK = '0;
    if (active) DACK[act_ch] = 1'b1;
  end

  assign HRQ       = !in_si;
  assign AEN       = active;
  assign ADSTB     = in_s1;
  assign ADDR      = active ? cur_addr[act_ch] : '0;
  assign MEMR_N    = !((in_s2 | in_s3) && act_mode.dir == DIR_READ);
  assign IOR_N     = !((in_s2 | in_s3) && act_mode.dir == DIR_WRITE);
  assign MEMW_N    = !(in_s3 && act_mode.dir == DIR_WRITE);
  assign IOW_N     = !(in_s3 && act_mode.dir == DIR_READ);
  assign EOP_N     = !(in_s4 && is_tc);
  assign tc_status = tc_q;

endmodule
